// File: rtl/eco_lane_logic_pipe.sv
// Per-lane runtime-selectable two-input gate with a 2-stage valid/ready pipeline,
// reduction flags on the result and a wrapping output-handshake counter.
module eco_lane_logic_pipe #(
  parameter  int WIDTH = 4,
  parameter  int CNT_W = 16,
  localparam int LW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we_i,
  input  logic [LW-1:0]    cfg_lane_i,
  input  logic [1:0]       cfg_op_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] y_o,
  output logic             y_par_o,
  output logic             y_all_o,
  output logic [CNT_W-1:0] out_cnt_o
);

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_ANDN = 2'b11
  } op_e;

  op_e              op_q [WIDTH];
  op_e              op_d [WIDTH];
  logic [WIDTH-1:0] lane_res;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             par_q, par_d;
  logic             all_q, all_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic s2_adv;
  logic accept;
  logic out_hs;

  // Lane indices past WIDTH never match any lane, so such writes drop silently.
  always_comb begin
    op_d = op_q;
    if (cfg_we_i) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (cfg_lane_i == LW'(i)) op_d[i] = op_e'(cfg_op_i);
      end
    end
  end

  always_comb begin
    lane_res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (op_q[i])
        OP_AND:  lane_res[i] = a_i[i] &  b_i[i];
        OP_OR:   lane_res[i] = a_i[i] |  b_i[i];
        OP_XOR:  lane_res[i] = a_i[i] ^  b_i[i];
        OP_ANDN: lane_res[i] = a_i[i] & ~b_i[i];
        default: lane_res[i] = 1'b0;
      endcase
    end
  end

  assign s2_adv     = s1_valid_q && (!s2_valid_q || out_ready_i);
  assign in_ready_o = !s1_valid_q || s2_adv;
  assign accept     = in_valid_i && in_ready_o;
  assign out_hs     = s2_valid_q && out_ready_i;

  // Stage 1 samples with the op table as it stood before this edge's write.
  always_comb begin
    s1_valid_d = s1_valid_q;
    z_d        = z_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      z_d        = lane_res;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    par_d      = par_q;
    all_d      = all_q;
    if (s2_adv) begin
      s2_valid_d = 1'b1;
      y_d        = z_q;
      par_d      = ^z_q;
      all_d      = &z_q;
    end else if (out_hs) begin
      s2_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_hs) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '{default: OP_AND};
      s1_valid_q <= 1'b0;
      z_q        <= '0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      par_q      <= 1'b0;
      all_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      op_q       <= op_d;
      s1_valid_q <= s1_valid_d;
      z_q        <= z_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      par_q      <= par_d;
      all_q      <= all_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign y_o         = y_q;
  assign y_par_o     = par_q;
  assign y_all_o     = all_q;
  assign out_cnt_o   = cnt_q;

endmodule

// File: tb/tb_eco_lane_logic_pipe.sv
// Bench for eco_lane_logic_pipe: directed scenarios on a 4-lane instance, a randomized
// run against a queue-based model, and 8-lane / 3-lane instances for lane-index edge cases.
module tb_eco_lane_logic_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  logic       cfgWe0, inValid0, inReady0, outValid0, outReady0, yPar0, yAll0;
  logic [1:0] cfgLane0, cfgOp0;
  logic [3:0] a0, b0, y0;
  logic [15:0] outCnt0;

  logic       cfgWe1, inValid1, inReady1, outValid1, outReady1, yPar1, yAll1;
  logic [2:0] cfgLane1;
  logic [1:0] cfgOp1;
  logic [7:0] a1, b1, y1;
  logic [2:0] outCnt1;

  logic       cfgWe2, inValid2, inReady2, outValid2, outReady2, yPar2, yAll2;
  logic [1:0] cfgLane2, cfgOp2;
  logic [2:0] a2, b2, y2;
  logic [3:0] outCnt2;

  eco_lane_logic_pipe #(.WIDTH(4), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .cfg_we_i(cfgWe0), .cfg_lane_i(cfgLane0), .cfg_op_i(cfgOp0),
    .in_valid_i(inValid0), .in_ready_o(inReady0), .a_i(a0), .b_i(b0),
    .out_valid_o(outValid0), .out_ready_i(outReady0), .y_o(y0), .y_par_o(yPar0),
    .y_all_o(yAll0), .out_cnt_o(outCnt0)
  );

  eco_lane_logic_pipe #(.WIDTH(8), .CNT_W(3)) u1 (
    .clk(clk), .rst_n(rst_n), .cfg_we_i(cfgWe1), .cfg_lane_i(cfgLane1), .cfg_op_i(cfgOp1),
    .in_valid_i(inValid1), .in_ready_o(inReady1), .a_i(a1), .b_i(b1),
    .out_valid_o(outValid1), .out_ready_i(outReady1), .y_o(y1), .y_par_o(yPar1),
    .y_all_o(yAll1), .out_cnt_o(outCnt1)
  );

  eco_lane_logic_pipe #(.WIDTH(3), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .cfg_we_i(cfgWe2), .cfg_lane_i(cfgLane2), .cfg_op_i(cfgOp2),
    .in_valid_i(inValid2), .in_ready_o(inReady2), .a_i(a2), .b_i(b2),
    .out_valid_o(outValid2), .out_ready_i(outReady2), .y_o(y2), .y_par_o(yPar2),
    .y_all_o(yAll2), .out_cnt_o(outCnt2)
  );

  // Reference gate evaluation: ops packs two op-code bits per lane, lane 0 lowest.
  function automatic logic [3:0] refY(input logic [7:0] ops, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      case (ops[2*i +: 2])
        2'd0: r[i] = a[i] & b[i];
        2'd1: r[i] = a[i] | b[i];
        2'd2: r[i] = a[i] ^ b[i];
        default: r[i] = a[i] & ~b[i];
      endcase
    end
    return r;
  endfunction

  task automatic idleInputs();
    cfgWe0 = 0; cfgLane0 = 0; cfgOp0 = 0; inValid0 = 0; a0 = 0; b0 = 0; outReady0 = 0;
    cfgWe1 = 0; cfgLane1 = 0; cfgOp1 = 0; inValid1 = 0; a1 = 0; b1 = 0; outReady1 = 0;
    cfgWe2 = 0; cfgLane2 = 0; cfgOp2 = 0; inValid2 = 0; a2 = 0; b2 = 0; outReady2 = 0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    idleInputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idleInputs();
    rst_n = 1'b0;
    #3;
    checks++; if (inReady0 !== 1'b1) $display("[TB] FAIL rst_in_ready got %b exp 1", inReady0); else passes++;
    checks++; if (outValid0 !== 1'b0) $display("[TB] FAIL rst_out_valid got %b exp 0", outValid0); else passes++;
    checks++; if (y0 !== 4'h0) $display("[TB] FAIL rst_y got %h exp 0", y0); else passes++;
    checks++; if ({yPar0, yAll0} !== 2'b00) $display("[TB] FAIL rst_flags got %b exp 00", {yPar0, yAll0}); else passes++;
    checks++; if (outCnt0 !== 16'd0) $display("[TB] FAIL rst_cnt got %0d exp 0", outCnt0); else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (inReady0 !== 1'b1) $display("[TB] FAIL rst_release_in_ready got %b exp 1", inReady0); else passes++;
  endtask

  task automatic test_default_ops();
    @(negedge clk);
    inValid0 = 1; a0 = 4'hF; b0 = 4'hA; outReady0 = 1;
    @(negedge clk);
    inValid0 = 0;
    #1;
    checks++; if (outValid0 !== 1'b0) $display("[TB] FAIL dflt_latency got %b exp 0", outValid0); else passes++;
    @(negedge clk); #1;
    checks++; if (outValid0 !== 1'b1) $display("[TB] FAIL dflt_valid got %b exp 1", outValid0); else passes++;
    checks++; if (y0 !== 4'hA) $display("[TB] FAIL dflt_y got %h exp a", y0); else passes++;
    checks++; if ({yPar0, yAll0} !== 2'b00) $display("[TB] FAIL dflt_flags got %b exp 00", {yPar0, yAll0}); else passes++;
    checks++; if (outCnt0 !== 16'd0) $display("[TB] FAIL dflt_cnt_pre got %0d exp 0", outCnt0); else passes++;
    @(negedge clk); #1;
    checks++; if (outValid0 !== 1'b0) $display("[TB] FAIL dflt_drain got %b exp 0", outValid0); else passes++;
    checks++; if (outCnt0 !== 16'd1) $display("[TB] FAIL dflt_cnt got %0d exp 1", outCnt0); else passes++;
    checks++; if (y0 !== 4'hA) $display("[TB] FAIL dflt_y_hold got %h exp a", y0); else passes++;
  endtask

  task automatic test_backpressure();
    resetDut();
    outReady0 = 0; inValid0 = 1; a0 = 4'h1; b0 = 4'hF;
    #1;
    checks++; if (inReady0 !== 1'b1) $display("[TB] FAIL bp_ir_first got %b exp 1", inReady0); else passes++;
    @(negedge clk);
    a0 = 4'h3;
    #1;
    checks++; if (inReady0 !== 1'b1) $display("[TB] FAIL bp_ir_second got %b exp 1", inReady0); else passes++;
    checks++; if (outValid0 !== 1'b0) $display("[TB] FAIL bp_ov_second got %b exp 0", outValid0); else passes++;
    @(negedge clk);
    a0 = 4'h7;
    #1;
    checks++; if (inReady0 !== 1'b0) $display("[TB] FAIL bp_ir_full got %b exp 0", inReady0); else passes++;
    checks++; if (outValid0 !== 1'b1) $display("[TB] FAIL bp_ov_full got %b exp 1", outValid0); else passes++;
    checks++; if (y0 !== 4'h1) $display("[TB] FAIL bp_y_full got %h exp 1", y0); else passes++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++; if (inReady0 !== 1'b0) $display("[TB] FAIL bp_ir_stall%0d got %b exp 0", i, inReady0); else passes++;
      checks++; if ({outValid0, y0} !== 5'h11) $display("[TB] FAIL bp_y_stall%0d got %b/%h exp 1/1", i, outValid0, y0); else passes++;
    end
    @(negedge clk);
    outReady0 = 1;
    #1;
    checks++; if (inReady0 !== 1'b1) $display("[TB] FAIL bp_ir_release got %b exp 1", inReady0); else passes++;
    @(negedge clk);
    inValid0 = 0;
    #1;
    checks++; if ({outValid0, y0} !== 5'h13) $display("[TB] FAIL bp_y2 got %b/%h exp 1/3", outValid0, y0); else passes++;
    @(negedge clk); #1;
    checks++; if ({outValid0, y0} !== 5'h17) $display("[TB] FAIL bp_y3 got %b/%h exp 1/7", outValid0, y0); else passes++;
    @(negedge clk); #1;
    checks++; if (outValid0 !== 1'b0) $display("[TB] FAIL bp_empty got %b exp 0", outValid0); else passes++;
    checks++; if (outCnt0 !== 16'd3) $display("[TB] FAIL bp_cnt got %0d exp 3", outCnt0); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] expY [8];
    resetDut();
    outReady0 = 1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        inValid0 = 1; a0 = 4'($urandom); b0 = 4'($urandom);
        expY[i] = a0 & b0;
      end else begin
        inValid0 = 0;
      end
      #1;
      checks++; if (inReady0 !== 1'b1) $display("[TB] FAIL b2b_ir%0d got %b exp 1", i, inReady0); else passes++;
      checks++; if (outValid0 !== (i >= 2)) $display("[TB] FAIL b2b_ov%0d got %b exp %b", i, outValid0, (i >= 2)); else passes++;
      if (i >= 2) begin
        checks++; if (y0 !== expY[i-2]) $display("[TB] FAIL b2b_y%0d got %h exp %h", i - 2, y0, expY[i-2]); else passes++;
      end
      @(negedge clk);
    end
    #1;
    checks++; if (outCnt0 !== 16'd8) $display("[TB] FAIL b2b_cnt got %0d exp 8", outCnt0); else passes++;
    checks++; if (outValid0 !== 1'b0) $display("[TB] FAIL b2b_drain got %b exp 0", outValid0); else passes++;
  endtask

  task automatic test_cfg_ops();
    @(negedge clk);
    outReady0 = 1; inValid0 = 0;
    cfgWe0 = 1; cfgLane0 = 2'd1; cfgOp0 = 2'b01;
    @(negedge clk);
    cfgLane0 = 2'd2; cfgOp0 = 2'b10;
    @(negedge clk);
    cfgLane0 = 2'd3; cfgOp0 = 2'b11;
    @(negedge clk);
    cfgWe0 = 0; inValid0 = 1; a0 = 4'b1100; b0 = 4'b0110;
    @(negedge clk);
    inValid0 = 0;
    @(negedge clk); #1;
    checks++; if ({outValid0, y0} !== 5'h1A) $display("[TB] FAIL cfg_y got %b/%h exp 1/a", outValid0, y0); else passes++;
    checks++; if ({yPar0, yAll0} !== 2'b00) $display("[TB] FAIL cfg_flags got %b exp 00", {yPar0, yAll0}); else passes++;
    cfgWe0 = 1; cfgLane0 = 2'd0; cfgOp0 = 2'b01;
    inValid0 = 1; a0 = 4'b0001; b0 = 4'b0000;
    @(negedge clk);
    cfgWe0 = 0;
    @(negedge clk);
    inValid0 = 0;
    #1;
    checks++; if ({outValid0, y0} !== 5'h10) $display("[TB] FAIL cfg_same_cycle_old got %b/%h exp 1/0", outValid0, y0); else passes++;
    @(negedge clk); #1;
    checks++; if ({outValid0, y0} !== 5'h11) $display("[TB] FAIL cfg_next_new got %b/%h exp 1/1", outValid0, y0); else passes++;
    checks++; if ({yPar0, yAll0} !== 2'b10) $display("[TB] FAIL cfg_next_flags got %b exp 10", {yPar0, yAll0}); else passes++;
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    outReady0 = 0; inValid0 = 1; a0 = 4'h5; b0 = 4'hF;
    @(negedge clk);
    a0 = 4'h6;
    @(negedge clk);
    inValid0 = 0;
    #1;
    checks++; if ({outValid0, inReady0} !== 2'b10) $display("[TB] FAIL mid_full got %b exp 10", {outValid0, inReady0}); else passes++;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (outValid0 !== 1'b0) $display("[TB] FAIL mid_rst_ov got %b exp 0", outValid0); else passes++;
    checks++; if (outCnt0 !== 16'd0) $display("[TB] FAIL mid_rst_cnt got %0d exp 0", outCnt0); else passes++;
    checks++; if ({inReady0, y0} !== 5'h10) $display("[TB] FAIL mid_rst_ir_y got %b/%h exp 1/0", inReady0, y0); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    outReady0 = 1; inValid0 = 1; a0 = 4'hF; b0 = 4'hF;
    @(negedge clk);
    inValid0 = 0;
    @(negedge clk); #1;
    checks++; if ({outValid0, y0} !== 5'h1F) $display("[TB] FAIL mid_post_y got %b/%h exp 1/f", outValid0, y0); else passes++;
    checks++; if ({yPar0, yAll0} !== 2'b01) $display("[TB] FAIL mid_post_flags got %b exp 01", {yPar0, yAll0}); else passes++;
  endtask

  // Model: a queue of in-flight results; a beat is visible once it has spent one cycle inside.
  task automatic test_random();
    logic [3:0]  q[$];
    logic [7:0]  opsM;
    logic [3:0]  lastY, expY, res;
    logic [15:0] cntM;
    logic        justAcc, expOv, expIr, acc, hs;
    resetDut();
    opsM = '0; lastY = '0; cntM = '0; justAcc = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      inValid0  = ($urandom_range(0, 3) != 0);
      a0        = 4'($urandom);
      b0        = 4'($urandom);
      outReady0 = ($urandom_range(0, 2) != 0);
      cfgWe0    = ($urandom_range(0, 5) == 0);
      cfgLane0  = 2'($urandom);
      cfgOp0    = 2'($urandom);
      #1;
      expOv = (q.size() >= 2) || (q.size() == 1 && !justAcc);
      expIr = (q.size() < 2) || outReady0;
      expY  = expOv ? q[0] : lastY;
      checks++; if (inReady0 !== expIr) $display("[TB] FAIL rnd_ir c%0d got %b exp %b", cyc, inReady0, expIr); else passes++;
      checks++; if (outValid0 !== expOv) $display("[TB] FAIL rnd_ov c%0d got %b exp %b", cyc, outValid0, expOv); else passes++;
      checks++; if (y0 !== expY) $display("[TB] FAIL rnd_y c%0d got %h exp %h", cyc, y0, expY); else passes++;
      checks++; if ({yPar0, yAll0} !== {^expY, &expY}) $display("[TB] FAIL rnd_flags c%0d got %b exp %b", cyc, {yPar0, yAll0}, {^expY, &expY}); else passes++;
      checks++; if (outCnt0 !== cntM) $display("[TB] FAIL rnd_cnt c%0d got %0d exp %0d", cyc, outCnt0, cntM); else passes++;
      acc = inValid0 && expIr;
      hs  = expOv && outReady0;
      res = refY(opsM, a0, b0);
      @(posedge clk);
      if (hs) begin
        lastY = q.pop_front();
        cntM  = cntM + 16'd1;
      end
      if (acc) q.push_back(res);
      justAcc = acc;
      if (cfgWe0) opsM[2*cfgLane0 +: 2] = cfgOp0;
    end
    @(negedge clk);
    cfgWe0 = 0; inValid0 = 0;
  endtask

  task automatic test_wide_lane();
    resetDut();
    cfgWe1 = 1; cfgLane1 = 3'd5; cfgOp1 = 2'b01; outReady1 = 1;
    @(negedge clk);
    cfgWe1 = 0; inValid1 = 1; a1 = 8'h00; b1 = 8'hFF;
    @(negedge clk);
    inValid1 = 0;
    @(negedge clk); #1;
    checks++; if ({outValid1, y1} !== 9'h120) $display("[TB] FAIL wide_lane5 got %b/%h exp 1/20", outValid1, y1); else passes++;
    checks++; if ({yPar1, yAll1} !== 2'b10) $display("[TB] FAIL wide_flags got %b exp 10", {yPar1, yAll1}); else passes++;
  endtask

  task automatic test_cnt_wrap();
    resetDut();
    outReady1 = 1;
    for (int i = 0; i < 8; i++) begin
      inValid1 = 1; a1 = 8'($urandom); b1 = 8'($urandom);
      @(negedge clk);
    end
    inValid1 = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (outCnt1 !== 3'd0) $display("[TB] FAIL wrap_cnt got %0d exp 0", outCnt1); else passes++;
    checks++; if (outValid1 !== 1'b0) $display("[TB] FAIL wrap_drain got %b exp 0", outValid1); else passes++;
    inValid1 = 1; a1 = 8'hFF; b1 = 8'hFF;
    @(negedge clk);
    inValid1 = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (outCnt1 !== 3'd1) $display("[TB] FAIL wrap_cnt_next got %0d exp 1", outCnt1); else passes++;
    checks++; if ({y1, yAll1} !== 9'h1FF) $display("[TB] FAIL wrap_y_hold got %h/%b exp ff/1", y1, yAll1); else passes++;
  endtask

  task automatic test_narrow_ignore();
    resetDut();
    cfgWe2 = 1; cfgLane2 = 2'd3; cfgOp2 = 2'b01; outReady2 = 1;
    @(negedge clk);
    cfgWe2 = 0; inValid2 = 1; a2 = 3'b000; b2 = 3'b111;
    @(negedge clk);
    a2 = 3'b111; b2 = 3'b101;
    @(negedge clk);
    inValid2 = 0;
    #1;
    checks++; if ({outValid2, y2} !== 4'b1000) $display("[TB] FAIL narrow_or_ignored got %b/%b exp 1/000", outValid2, y2); else passes++;
    @(negedge clk); #1;
    checks++; if ({outValid2, y2} !== 4'b1101) $display("[TB] FAIL narrow_and got %b/%b exp 1/101", outValid2, y2); else passes++;
    checks++; if ({yPar2, yAll2} !== 2'b00) $display("[TB] FAIL narrow_flags got %b exp 00", {yPar2, yAll2}); else passes++;
    @(negedge clk); #1;
    checks++; if (outCnt2 !== 4'd2) $display("[TB] FAIL narrow_cnt got %0d exp 2", outCnt2); else passes++;
  endtask

  initial begin
    test_reset();
    test_default_ops();
    test_backpressure();
    test_back_to_back();
    test_cfg_ops();
    test_reset_midflight();
    test_random();
    test_wide_lane();
    test_cnt_wrap();
    test_narrow_ignore();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired after %0d/%0d checks", passes, checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
